// File: rtl/water_level_pkg.sv
// Shared level codes, sensor patterns and FSM states for the water-level display path.
package water_level_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LVL_CRITICAL = 2'b00;
  localparam level_t LVL_LOW      = 2'b01;
  localparam level_t LVL_MID      = 2'b10;
  localparam level_t LVL_HIGH     = 2'b11;

  localparam logic [2:0] SNS_EMPTY = 3'b000;
  localparam logic [2:0] SNS_LOW   = 3'b001;
  localparam logic [2:0] SNS_MID   = 3'b011;
  localparam logic [2:0] SNS_FULL  = 3'b111;

  typedef enum logic [1:0] {SETTLE, TRACK, FAULT} state_t;

  typedef struct packed {
    logic   ok;
    level_t code;
  } class_t;

  // Only the physically possible "filled from the bottom" patterns are valid.
  function automatic class_t classify(input logic [2:0] pattern);
    class_t c;
    c = '{ok: 1'b1, code: LVL_CRITICAL};
    case (pattern)
      SNS_EMPTY: c.code = LVL_CRITICAL;
      SNS_LOW:   c.code = LVL_LOW;
      SNS_MID:   c.code = LVL_MID;
      SNS_FULL:  c.code = LVL_HIGH;
      default:   c.ok   = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/water_level_encoder_if.sv
// Level bus from the encoder to the LED-matrix decoder and irrigation controller.
interface water_level_encoder_if;
  import water_level_pkg::*;

  level_t level;
  logic   level_valid;
  logic   level_changed;
  logic   sensor_fault;

  modport master (output level, output level_valid, output level_changed, output sensor_fault);
  modport slave  (input  level, input  level_valid, input  level_changed, input  sensor_fault);
endinterface

// File: rtl/water_level_encoder_sensor_debouncer.sv
// Two-flop synchroniser plus saturating stability counter; strobes once per stable pattern.
module sensor_debouncer #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cand,
  output logic             accept
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt;

  // Strobe on the edge that takes cnt to its limit; a saturated counter stays quiet.
  assign accept = (sync2 == cand) && (cnt == CNT_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/water_level_encoder.sv
// Debounces the float switches, validates the pattern and tracks the 2-bit level code.
module water_level_encoder
  import water_level_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    sensor,
  water_level_encoder_if.master         lvl_bus
);

  logic [2:0] cand;
  logic       accept;
  class_t     cls;
  state_t     state;
  level_t     level;
  logic       level_valid;
  logic       level_changed;

  sensor_debouncer #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (sensor),
    .cand   (cand),
    .accept (accept)
  );

  assign cls = classify(cand);

  // level is 00 throughout SETTLE, so a first accept of 00 produces no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SETTLE;
      level         <= LVL_CRITICAL;
      level_valid   <= 1'b0;
      level_changed <= 1'b0;
    end else begin
      level_changed <= 1'b0;
      if (accept) begin
        if (cls.ok) begin
          state         <= TRACK;
          level         <= cls.code;
          level_valid   <= 1'b1;
          level_changed <= (cls.code != level);
        end else begin
          state <= FAULT;
        end
      end
    end
  end

  assign lvl_bus.level         = level;
  assign lvl_bus.level_valid   = level_valid;
  assign lvl_bus.level_changed = level_changed;
  assign lvl_bus.sensor_fault  = (state == FAULT);

endmodule

// File: tb/tb_water_level_encoder.sv
// Directed vector bench for water_level_encoder at DEBOUNCE_CYCLES 4 and 1023.
module tb_water_level_encoder;

  logic       clk;
  logic       rst_n_a;
  logic       rst_n_b;
  logic [2:0] sens_a;
  logic [2:0] sens_b;
  int         tests;
  int         failed;

  water_level_encoder_if if_a ();
  water_level_encoder_if if_b ();

  water_level_encoder #(.DEBOUNCE_CYCLES(4)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n_a),
    .sensor  (sens_a),
    .lvl_bus (if_a)
  );

  water_level_encoder #(.DEBOUNCE_CYCLES(1023)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n_b),
    .sensor  (sens_b),
    .lvl_bus (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] sensor;
    int         hold;
    int         edge_at;
    logic [1:0] lvl;
    logic       vld;
    logic       flt;
    int         pulses;
    string      name;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] prev_lvl;
    logic       prev_flt;
    int         pulses;

    tests  = 0;
    failed = 0;

    vecs[0]  = '{3'b000,  5, 0, 2'b00, 1'b1, 1'b0, 0, "powerup_000"};
    vecs[1]  = '{3'b001, 10, 6, 2'b01, 1'b1, 1'b0, 1, "step_001"};
    vecs[2]  = '{3'b011, 10, 6, 2'b10, 1'b1, 1'b0, 1, "step_011"};
    vecs[3]  = '{3'b111, 10, 6, 2'b11, 1'b1, 1'b0, 1, "step_111"};
    vecs[4]  = '{3'b011, 10, 6, 2'b10, 1'b1, 1'b0, 1, "down_011"};
    vecs[5]  = '{3'b111,  3, 0, 2'b10, 1'b1, 1'b0, 0, "glitch_111"};
    vecs[6]  = '{3'b011, 10, 0, 2'b10, 1'b1, 1'b0, 0, "after_glitch"};
    vecs[7]  = '{3'b001, 10, 6, 2'b01, 1'b1, 1'b0, 1, "down_001"};
    vecs[8]  = '{3'b101, 10, 6, 2'b01, 1'b1, 1'b1, 0, "fault_101"};
    vecs[9]  = '{3'b001, 10, 6, 2'b01, 1'b1, 1'b0, 0, "clear_001"};
    vecs[10] = '{3'b110, 10, 6, 2'b01, 1'b1, 1'b1, 0, "fault_110"};
    vecs[11] = '{3'b100, 10, 0, 2'b01, 1'b1, 1'b1, 0, "fault_100"};
    vecs[12] = '{3'b010, 10, 0, 2'b01, 1'b1, 1'b1, 0, "fault_010"};
    vecs[13] = '{3'b000, 10, 6, 2'b00, 1'b1, 1'b0, 1, "recover_000"};
    vecs[14] = '{3'b111, 10, 6, 2'b11, 1'b1, 1'b0, 1, "jump_111"};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    sens_a  = 3'b000;
    sens_b  = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    check("rst.level",   32'(if_a.level),         32'h0);
    check("rst.valid",   32'(if_a.level_valid),   32'h0);
    check("rst.changed", 32'(if_a.level_changed), 32'h0);
    check("rst.fault",   32'(if_a.sensor_fault),  32'h0);
    @(negedge clk);
    rst_n_a = 1'b1;

    prev_lvl = 2'b00;
    prev_flt = 1'b0;
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      sens_a = vecs[v].sensor;
      pulses = 0;
      for (int i = 1; i <= vecs[v].hold; i++) begin
        @(posedge clk);
        #1;
        if (if_a.level_changed) pulses++;
        if (vecs[v].edge_at != 0 && i == vecs[v].edge_at - 1) begin
          check({vecs[v].name, ".level_early"}, 32'(if_a.level),        32'(prev_lvl));
          check({vecs[v].name, ".fault_early"}, 32'(if_a.sensor_fault), 32'(prev_flt));
        end
        if (vecs[v].edge_at != 0 && i == vecs[v].edge_at) begin
          check({vecs[v].name, ".level_edge"}, 32'(if_a.level),        32'(vecs[v].lvl));
          check({vecs[v].name, ".fault_edge"}, 32'(if_a.sensor_fault), 32'(vecs[v].flt));
        end
      end
      check({vecs[v].name, ".level"},  32'(if_a.level),        32'(vecs[v].lvl));
      check({vecs[v].name, ".valid"},  32'(if_a.level_valid),  32'(vecs[v].vld));
      check({vecs[v].name, ".fault"},  32'(if_a.sensor_fault), 32'(vecs[v].flt));
      check({vecs[v].name, ".pulses"}, 32'(pulses),            32'(vecs[v].pulses));
      prev_lvl = vecs[v].lvl;
      prev_flt = vecs[v].flt;
    end

    // Asynchronous reset partway through a 011 debounce, level currently 11.
    @(negedge clk);
    sens_a = 3'b011;
    repeat (4) @(posedge clk);
    #2;
    rst_n_a = 1'b0;
    #1;
    check("async_rst.level",   32'(if_a.level),         32'h0);
    check("async_rst.valid",   32'(if_a.level_valid),   32'h0);
    check("async_rst.changed", 32'(if_a.level_changed), 32'h0);
    check("async_rst.fault",   32'(if_a.sensor_fault),  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin
        check("post_rst.level_early", 32'(if_a.level),       32'h0);
        check("post_rst.valid_early", 32'(if_a.level_valid), 32'h0);
      end
      if (i == 6) begin
        check("post_rst.level",   32'(if_a.level),         32'h2);
        check("post_rst.valid",   32'(if_a.level_valid),   32'h1);
        check("post_rst.changed", 32'(if_a.level_changed), 32'h1);
      end
    end

    // Long debounce: one accept only, counter saturates without re-accepting.
    @(negedge clk);
    rst_n_b = 1'b1;
    pulses  = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (if_b.level_changed) pulses++;
      if (i == 1024) check("long.level_early", 32'(if_b.level), 32'h0);
      if (i == 1025) begin
        check("long.level_edge",   32'(if_b.level),         32'h1);
        check("long.changed_edge", 32'(if_b.level_changed), 32'h1);
      end
    end
    check("long.pulses", 32'(pulses),             32'h1);
    check("long.level",  32'(if_b.level),         32'h1);
    check("long.valid",  32'(if_b.level_valid),   32'h1);
    check("long.fault",  32'(if_b.sensor_fault),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
